// File: rtl/encoder_pkg.sv
// Shared definitions for the quadrature encoder generator: FSM state
// encoding and the default counter width.
package encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/quad_encoder_gen_if.sv
// Control/status bundle of the quadrature encoder generator. The master
// side launches and configures the generator; the slave side is the
// generator itself.
interface quad_encoder_gen_if #(
  parameter int CNT_W = encoder_pkg::DEFAULT_CNT_W
);
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] burst_num;
  logic             direction;
  logic             enc_a;
  logic             enc_b;
  logic             enc_z;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] period_cnt;

  modport master (
    output start, stop, period, half, phase, burst_num, direction,
    input  enc_a, enc_b, enc_z, busy, done, period_cnt
  );

  modport slave (
    input  start, stop, period, half, phase, burst_num, direction,
    output enc_a, enc_b, enc_z, busy, done, period_cnt
  );
endinterface

// File: rtl/encoder_phase_decode.sv
// Per-channel level decode: a channel sits at its active level while the
// position within the period is at or below the half-period point.
module encoder_phase_decode #(
  parameter int CNT_W    = encoder_pkg::DEFAULT_CNT_W,
  parameter bit POLARITY = 1'b1
) (
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] half,
  output logic             level
);

  assign level = (count <= half) ? POLARITY : ~POLARITY;

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder waveform generator (A/B with programmable phase lag,
// optional index pulse Z). Optional feature macro: ENCODER_INDEX_EN adds
// the index channel; without it enc_z is tied to IDLE_LEVEL.
module quad_encoder_gen
  import encoder_pkg::*;
#(
  parameter int CNT_W      = DEFAULT_CNT_W,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter bit POLARITY   = 1'b1,
  parameter int INDEX_DIV  = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  quad_encoder_gen_if.slave    bus
);

  if (INDEX_DIV < 1) begin : g_bad_index_div
    $error("INDEX_DIV must be at least 1");
  end

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, period_cnt;
  logic [CNT_W-1:0] sh_period, sh_half, sh_phase, sh_burst;
  logic             sh_dir, stop_pend;
  logic             enc_a_q, enc_b_q, enc_z_q;
  logic             launch, wrap, last_wrap;
  logic [CNT_W-1:0] bcnt;
  logic             raw_a, raw_b;

  assign launch    = (state == ST_IDLE) && bus.start && (bus.period != '0);
  assign wrap      = (state == ST_RUN) && (cnt == sh_period);
  assign last_wrap = wrap && (stop_pend ||
                     ((sh_burst != '0) && (period_cnt + CNT_W'(1) == sh_burst)));

  // B position lags A by sh_phase, wrapping around the period. Modular
  // arithmetic keeps the intermediate sum correct even at full width.
  assign bcnt = (cnt >= sh_phase) ? cnt - sh_phase
                                  : cnt + sh_period + CNT_W'(1) - sh_phase;

  encoder_phase_decode #(.CNT_W(CNT_W), .POLARITY(POLARITY)) u_dec_a (
    .count (cnt),
    .half  (sh_half),
    .level (raw_a)
  );

  encoder_phase_decode #(.CNT_W(CNT_W), .POLARITY(POLARITY)) u_dec_b (
    .count (bcnt),
    .half  (sh_half),
    .level (raw_b)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state decode.
  // NOTE: the default assignment first means every path assigns state_n,
  // so no latch is inferred.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (launch)    state_n = ST_RUN;
      ST_RUN:    if (last_wrap) state_n = ST_FINISH;
      ST_FINISH:                state_n = ST_IDLE;
      default:                  state_n = ST_IDLE;
    endcase
  end

  // Shadow configuration, position counter, period counter and stop flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt        <= '0;
      period_cnt <= '0;
      stop_pend  <= 1'b0;
      sh_period  <= '0;
      sh_half    <= '0;
      sh_phase   <= '0;
      sh_burst   <= '0;
      sh_dir     <= 1'b0;
    end else if (launch) begin
      sh_period  <= bus.period;
      sh_half    <= bus.half;
      sh_phase   <= (bus.phase > bus.period) ? bus.period : bus.phase;
      sh_burst   <= bus.burst_num;
      sh_dir     <= bus.direction;
      cnt        <= '0;
      period_cnt <= '0;
      stop_pend  <= 1'b0;
    end else if (state == ST_RUN) begin
      if (bus.stop) stop_pend <= 1'b1;
      if (wrap) begin
        cnt        <= '0;
        period_cnt <= period_cnt + CNT_W'(1);
        sh_dir     <= bus.direction;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Registered A/B outputs, swapped when B is to lead.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      enc_a_q <= IDLE_LEVEL;
      enc_b_q <= IDLE_LEVEL;
    end else if (state == ST_RUN) begin
      enc_a_q <= sh_dir ? raw_b : raw_a;
      enc_b_q <= sh_dir ? raw_a : raw_b;
    end else begin
      enc_a_q <= IDLE_LEVEL;
      enc_b_q <= IDLE_LEVEL;
    end
  end

`ifdef ENCODER_INDEX_EN
  localparam int IDX_W = (INDEX_DIV > 1) ? $clog2(INDEX_DIV) : 1;

  logic [IDX_W-1:0] idx_cnt;

  // Modulo-INDEX_DIV period counter selecting which periods carry an index.
  always_ff @(posedge clk) begin
    if (!rstn)       idx_cnt <= '0;
    else if (launch) idx_cnt <= '0;
    else if (wrap)   idx_cnt <= (idx_cnt == IDX_W'(INDEX_DIV - 1)) ? '0
                                                                  : idx_cnt + IDX_W'(1);
  end

  // Index pulse at position 0 of each selected period, aligned with A/B.
  always_ff @(posedge clk) begin
    if (!rstn)                 enc_z_q <= IDLE_LEVEL;
    else if (state == ST_RUN)  enc_z_q <= ((cnt == '0) && (idx_cnt == '0)) ? POLARITY : ~POLARITY;
    else                       enc_z_q <= IDLE_LEVEL;
  end
`else
  assign enc_z_q = IDLE_LEVEL;
`endif

  assign bus.enc_a      = enc_a_q;
  assign bus.enc_b      = enc_b_q;
  assign bus.enc_z      = enc_z_q;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_FINISH);
  assign bus.period_cnt = period_cnt;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench for quad_encoder_gen: a behavioural model predicts
// every output each cycle, and directed runs pin waveform shapes to
// hand-derived literals. Honours ENCODER_INDEX_EN for the index channel.
module tb_quad_encoder_gen;

  localparam int CNT_W = 16;
  localparam bit POL   = 1'b1;
  localparam bit IDL   = 1'b0;
  localparam int DIV   = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  quad_encoder_gen_if #(.CNT_W(CNT_W)) bus ();

  quad_encoder_gen #(.CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Mode: 0 idle, 1 running, 2 finishing. Position/period count tracked as
  // plain integers; channel levels derived from the position arithmetic.
  int m_mode = 0, m_pos = 0, m_pc = 0, m_idx = 0;
  int m_p = 0, m_h = 0, m_ph = 0, m_b = 0;
  bit m_dir = 0, m_stop = 0;
  bit exp_a = IDL, exp_b = IDL, exp_z = IDL;

  function automatic bit lvl(input int c, input int h);
    return (c <= h) ? POL : !POL;
  endfunction

  always @(posedge clk) begin
    bit la, lb;
    if (!rstn) begin
      m_mode = 0; m_pc = 0; m_stop = 0; m_idx = 0;
      exp_a = IDL; exp_b = IDL; exp_z = IDL;
    end else begin
      case (m_mode)
        0: begin
          exp_a = IDL; exp_b = IDL; exp_z = IDL;
          if (bus.start && bus.period != 0) begin
            m_p    = int'(bus.period);
            m_h    = int'(bus.half);
            m_ph   = (bus.phase > bus.period) ? int'(bus.period) : int'(bus.phase);
            m_b    = int'(bus.burst_num);
            m_dir  = bus.direction;
            m_pos  = 0; m_pc = 0; m_stop = 0; m_idx = 0;
            m_mode = 1;
          end
        end
        1: begin
          la = lvl(m_pos, m_h);
          lb = lvl((m_pos + m_p + 1 - m_ph) % (m_p + 1), m_h);
          exp_a = m_dir ? lb : la;
          exp_b = m_dir ? la : lb;
`ifdef ENCODER_INDEX_EN
          exp_z = (m_pos == 0 && m_idx == 0) ? POL : !POL;
`else
          exp_z = IDL;
`endif
          if (m_pos == m_p) begin
            m_pc++;
            m_dir = bus.direction;
            m_idx = (m_idx + 1) % DIV;
            m_pos = 0;
            if (m_stop || (m_b != 0 && m_pc == m_b)) m_mode = 2;
          end else begin
            m_pos++;
          end
          if (bus.stop) m_stop = 1;
        end
        default: begin
          exp_a = IDL; exp_b = IDL; exp_z = IDL;
          m_mode = 0;
        end
      endcase
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("enc_a", bus.enc_a, exp_a);
      check("enc_b", bus.enc_b, exp_b);
      check("enc_z", bus.enc_z, exp_z);
      check("busy", bus.busy, m_mode != 0);
      check("done", bus.done, m_mode == 2);
      check("period_cnt", bus.period_cnt, m_pc);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_capture(input int p, input int h, input int ph, input int b,
                             input bit dir, input int n, input int flip,
                             output logic [63:0] av, output logic [63:0] bv,
                             output logic [63:0] zv, output int dcnt, output int dlast);
    @(negedge clk);
    bus.period = CNT_W'(p); bus.half = CNT_W'(h); bus.phase = CNT_W'(ph);
    bus.burst_num = CNT_W'(b); bus.direction = dir; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    av = '0; bv = '0; zv = '0; dcnt = 0; dlast = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      av = {av[62:0], bus.enc_a};
      bv = {bv[62:0], bus.enc_b};
      zv = {zv[62:0], bus.enc_z};
      if (bus.done) begin dcnt++; dlast = i; end
      if (i == flip) bus.direction = ~bus.direction;
    end
  endtask

  logic [63:0] av, bv, zv;
  int dcnt, dlast;

  initial begin
    bus.start = 0; bus.stop = 0; bus.direction = 0;
    bus.period = '0; bus.half = '0; bus.phase = '0; bus.burst_num = '0;
    rstn = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_enc_a", bus.enc_a, IDL);
    check("reset_pcnt", bus.period_cnt, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Basic burst: A high 4 / low 4, B lagging by 2.
    run_capture(7, 3, 2, 3, 0, 24, -1, av, bv, zv, dcnt, dlast);
    check("burst_a_shape", av[23:0], 24'hF0F0F0);
    check("burst_b_shape", bv[23:0], 24'h3C3C3C);
    check("burst_done_count", dcnt, 1);
    check("burst_done_at", dlast, 23);
    @(negedge clk);
    check("burst_end_busy", bus.busy, 0);
    check("burst_end_pcnt", bus.period_cnt, 3);
    check("burst_end_enc_a", bus.enc_a, IDL);

    // Reverse direction: B leads A.
    run_capture(7, 3, 2, 3, 1, 24, -1, av, bv, zv, dcnt, dlast);
    check("rev_a_shape", av[23:0], 24'h3C3C3C);
    check("rev_b_shape", bv[23:0], 24'hF0F0F0);
    @(negedge clk);

    // Direction toggled mid-period: swap appears only at the next wrap.
    run_capture(7, 3, 2, 2, 0, 16, 1, av, bv, zv, dcnt, dlast);
    check("flip_a_shape", av[15:0], 16'hF03C);
    check("flip_b_shape", bv[15:0], 16'h3CF0);
    bus.direction = 0;
    @(negedge clk);

    // Oversized phase saturates to the period: B lags 7 clocks.
    run_capture(7, 3, 20, 1, 0, 8, -1, av, bv, zv, dcnt, dlast);
    check("satph_a_shape", av[7:0], 8'hF0);
    check("satph_b_shape", bv[7:0], 8'hE1);
    repeat (2) @(negedge clk);

    // Index pulses: periods 0 and 4 of an 8-period burst.
    run_capture(3, 1, 0, 8, 0, 32, -1, av, bv, zv, dcnt, dlast);
`ifdef ENCODER_INDEX_EN
    check("index_shape", zv[31:0], 32'h8000_8000);
`else
    check("index_shape", zv[31:0], 32'h0000_0000);
`endif
    repeat (2) @(negedge clk);

    // Continuous run stopped at cnt=3 of period 5.
    @(negedge clk);
    bus.period = 7; bus.half = 3; bus.phase = 2; bus.burst_num = 0; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    repeat (43) @(negedge clk);
    bus.stop = 1;
    @(negedge clk);
    bus.stop = 0;
    dcnt = 0;
    for (int i = 0; i < 40 && dcnt == 0; i++) begin
      @(negedge clk);
      if (bus.done) dcnt = 1;
    end
    check("stop_done_seen", dcnt, 1);
    check("stop_pcnt", bus.period_cnt, 6);
    @(negedge clk);
    check("stop_idle_a", bus.enc_a, IDL);
    check("stop_idle_busy", bus.busy, 0);
    check("stop_hold_pcnt", bus.period_cnt, 6);

    // Reset in the middle of a run.
    bus.period = 7; bus.burst_num = 0; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    repeat (10) @(negedge clk);
    rstn = 0;
    @(negedge clk);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_ab", {bus.enc_a, bus.enc_b, bus.enc_z}, {IDL, IDL, IDL});
    check("midrst_pcnt", bus.period_cnt, 0);
    rstn = 1;

    // Start with period 0 is ignored.
    @(negedge clk);
    bus.period = 0; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    check("p0_busy", bus.busy, 0);
    @(negedge clk);
    check("p0_busy_later", bus.busy, 0);

    // Randomized transactions against the model.
    for (int t = 0; t < 40; t++) begin
      int c, stop_at;
      bit finished;
      @(negedge clk);
      bus.period    = ($urandom_range(0, 7) == 0) ? CNT_W'(0) : CNT_W'($urandom_range(1, 12));
      bus.half      = CNT_W'($urandom_range(0, 14));
      bus.phase     = CNT_W'($urandom_range(0, 15));
      bus.burst_num = CNT_W'($urandom_range(0, 4));
      bus.direction = 1'($urandom_range(0, 1));
      bus.stop      = ($urandom_range(0, 3) == 0);
      bus.start     = 1'b1;
      stop_at  = $urandom_range(1, 60);
      c        = 0;
      finished = 1'b0;
      while (!finished && c < 300) begin
        @(negedge clk);
        c++;
        if (m_mode == 0) begin
          finished  = 1'b1;
          bus.start = 0; bus.stop = 0; rstn = 1;
        end else begin
          rstn      = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
          bus.start = ($urandom_range(0, 9) == 0);
          bus.stop  = ((bus.burst_num == 0) && (c == stop_at)) || ($urandom_range(0, 39) == 0);
          if ($urandom_range(0, 5) == 0) bus.direction = ~bus.direction;
        end
      end
      check("run_bounded", finished, 1);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_encoder_gen.md
QUAD_ENCODER_GEN -- requirements
Module: quad_encoder_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of all counters and timing inputs.
REQ-002 SHALL have parameter IDLE_LEVEL, default 0, level of enc_a/enc_b/enc_z when not running.
REQ-003 SHALL have parameter POLARITY, default 1, active level of the first half-period and of the index pulse.
REQ-004 SHALL have parameter INDEX_DIV, default 4, number of periods per index pulse (>=1).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rstn, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have port start, input, 1, launch request.
REQ-008 SHALL have port stop, input, 1, graceful stop request.
REQ-009 SHALL have port period, input, CNT_W, last count value; waveform period = period+1 clocks.
REQ-010 SHALL have port half, input, CNT_W, last count value at the active level.
REQ-011 SHALL have port phase, input, CNT_W, B-channel lag in clocks.
REQ-012 SHALL have port burst_num, input, CNT_W, periods to generate; 0 = continuous.
REQ-013 SHALL have port direction, input, 1, 0 = A leads B, 1 = B leads A.
REQ-014 SHALL have ports enc_a, enc_b, enc_z, output, 1 each, registered encoder outputs.
REQ-015 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse), period_cnt (output, CNT_W, completed periods).

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> FINISH -> IDLE; FINISH lasts exactly one cycle.
REQ-017 In IDLE, start=1 with period!=0 SHALL latch period/half/phase/burst_num/direction into shadow registers and enter RUN with cnt=0, period_cnt=0; start with period=0 SHALL be ignored.
REQ-018 In RUN, cnt SHALL increment each cycle and wrap from shadow period to 0; period_cnt SHALL increment on each wrap.
REQ-019 Raw A SHALL be POLARITY when cnt<=half, else ~POLARITY; half>=period yields constant POLARITY.
REQ-020 Raw B SHALL be the raw A decode of bcnt = (cnt>=phase) ? cnt-phase : cnt+period+1-phase; phase>period SHALL saturate to period.
REQ-021 enc_a/enc_b SHALL be raw A/B when direction shadow=0, swapped when 1, registered with 1-cycle latency from cnt.
REQ-022 Direction shadow SHALL re-sample the direction input at every wrap (cnt period->0); other shadows only at start.
REQ-023 Burst: with burst_num!=0, the wrap completing period number burst_num SHALL move RUN -> FINISH.
REQ-024 stop=1 in RUN SHALL set a pending flag; the next wrap SHALL move RUN -> FINISH; stop in IDLE/FINISH ignored.
REQ-025 start in RUN/FINISH SHALL be ignored; start and stop together in IDLE SHALL start.
REQ-026 FINISH SHALL pulse done=1 for one cycle; busy SHALL be 1 in RUN and FINISH only.
REQ-027 Outside RUN, enc_a/enc_b/enc_z SHALL be IDLE_LEVEL from the cycle after leaving RUN; period_cnt SHALL hold its final value until next start.

Reset
REQ-028 rstn=0 at a clock edge SHALL force IDLE, cnt=0, period_cnt=0, stop flag=0, index count=0, busy=0, done=0, enc_a/enc_b/enc_z=IDLE_LEVEL, including mid-RUN with no done pulse.

Configuration
REQ-029 With macro ENCODER_INDEX_EN defined, enc_z SHALL be POLARITY for one cycle (same latency as enc_a) at cnt=0 of every INDEX_DIV-th period starting with period 0, using a modulo-INDEX_DIV period counter cleared at start.
REQ-030 Without ENCODER_INDEX_EN, enc_z SHALL be constant IDLE_LEVEL and no index counter logic SHALL exist.

Structure
REQ-031 FSM state encoding (IDLE/RUN/FINISH) and default CNT_W SHALL live in shared package encoder_pkg.
REQ-032 Per-channel level decode (count, half, POLARITY -> level) SHALL be sub-module encoder_phase_decode, instantiated twice (A, B).

Verification
REQ-033 period=7, half=3, phase=2, burst_num=3, dir=0, start pulse -> enc_a 4 high/4 low x3, enc_b identical lagging 2 clocks, done once after 24 RUN cycles, period_cnt=3.
REQ-034 Same with dir=1 -> enc_b leads enc_a by 2 clocks; toggle direction mid-period -> swap occurs at next wrap only.
REQ-035 burst_num=0, stop asserted at cnt=3 of period 5 -> period 5 completes, done pulses, period_cnt=6, outputs return to IDLE_LEVEL.
REQ-036 ENCODER_INDEX_EN, INDEX_DIV=4, period=3, burst_num=8 -> enc_z one-cycle pulses at start of periods 0 and 4 only; without macro enc_z stays IDLE_LEVEL.
REQ-037 rstn low mid-RUN -> next edge all outputs at reset values, no done; phase=20 with period=7 -> B lags 7 clocks; start with period=0 -> stays IDLE.
